keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans a ROWS x COLS switch matrix by driving one row at a time and sampling the column lines.
- Debounces every key with a per-key scan counter and keeps a debounced key-state vector.
- Emits press/release events through a small FIFO with a valid/ready handshake.
- Sits between the board keypad pins and the input/controller logic; it replaces per-pin debounce instances with one time-multiplexed scheduler.

Parameters:
- ROWS, 4, number of driven row lines.
- COLS, 4, number of sampled column lines.
- SETTLE_CYCLES, 16, cycles a row is driven before sampling; must be >= 3 to cover the 2-FF synchronizer.
- DEBOUNCE_SCANS, 4, consecutive scans a changed raw value must persist before the debounced state flips; must be >= 1.
- FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scanning enabled.
- row_o  out  ROWS  one-hot row drive, active-high.
- col_i  in  COLS  raw column inputs, asynchronous; 2-FF synchronized internally.
- keys_o  out  ROWS*COLS  debounced key state; bit index = row*COLS+col.
- event_valid  out  1  FIFO not empty.
- event_ready  in  1  consumer accepts the head event.
- event_key  out  $clog2(ROWS*COLS)  key index of the head event.
- event_press  out  1  1 = press, 0 = release.
- overflow  out  1  sticky flag: an event was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (asynchronous, active-high): all registers clear immediately, independent of clk.
  - row_o=0, keys_o=0, event_valid=0, overflow=0.
  - FIFO empty, all per-key counters 0, FSM in IDLE, synchronizer flops 0.
- FSM states:
  - IDLE: row_o=0, row index=0. Goes to DRIVE on the first clk edge with enable=1.
  - DRIVE: row_o=1<<row. Counts SETTLE_CYCLES cycles, then goes to SAMPLE.
  - SAMPLE: 1 cycle. Latches the synchronized col_i into a row buffer, then goes to EMIT.
  - EMIT: COLS cycles, column c processed in the c-th cycle.
  - After the last EMIT cycle:
    - if enable=0, go to IDLE;
    - else row wraps ROWS-1 -> 0 and the FSM returns to DRIVE.
  - row_o is held from DRIVE through the end of EMIT.
- Timing: row period = SETTLE_CYCLES+1+COLS cycles; full scan = ROWS times the row period.
- enable deasserted mid-row: the current row completes; keys_o and the FIFO are retained.
- Per-key debounce, evaluated in EMIT for key k:
  - raw == keys_o[k]: counter cleared.
  - raw != keys_o[k] and counter < DEBOUNCE_SCANS-1: counter increments.
  - raw != keys_o[k] and counter == DEBOUNCE_SCANS-1: keys_o[k] toggles on the next edge, counter cleared, event generated.
  - Counter width: $clog2(DEBOUNCE_SCANS+1).
- Events:
  - At most one push per cycle, which follows from the one-column-per-EMIT-cycle processing.
  - Push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the event is dropped, overflow<=1, and keys_o still updates.
- FIFO:
  - Pop when event_valid & event_ready.
  - event_key and event_press always show the head entry and are stable while valid & !ready.
  - Simultaneous push and pop when empty: the pushed entry becomes visible the next cycle; there is no bypass.
  - Occupancy never exceeds FIFO_DEPTH.
- overflow: overflow_clr clears it. If a drop and a clear occur in the same cycle, the set wins.
- Ghosting/multi-key: not resolved. Each key is debounced independently from its raw sample.

Optional Feature:
- Macro: KEYPAD_SCANNER_RELEASE_EVENT_EN.
- Defined: both press and release transitions push events.
- Undefined:
  - only press transitions (0->1) push events;
  - release still clears keys_o[k] and its counter, but pushes nothing and cannot set overflow;
  - event_press is tied to 1.

Test Plan:
All scenarios use ROWS=4, COLS=4, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4; row period 9 cycles, scan 36 cycles.
- Reset/start: rst pulse, then enable=1 -> row_o=4'b0000 during reset; 4'b0001 the cycle after the first enabled edge; 4'b0010 nine cycles later; keys_o=0; event_valid=0.
- Press: hold key row2/col1 from cycle 0, event_ready=1 -> keys_o[9]=1 after the 3rd scan's row-2 EMIT; exactly one event (key=9, press=1); no further events while held.
- Bounce: toggle key 5's raw level every scan for 10 scans -> keys_o[5] stays 0; no events.
- Release: release key 9 for 3 scans -> with macro, one event (key=9, press=0); without macro, no event and keys_o[9]=0.
- Overflow/backpressure: event_ready=0, press keys 0,1,2,3,4 -> 4 events held in order 0..3; overflow=1; keys_o[4:0]=5'h1F. Pulse overflow_clr -> overflow=0. Drain with ready=1 -> events 0,1,2,3, then event_valid=0.
- Reset mid-operation: assert rst asynchronously during EMIT with 2 events queued -> event_valid, row_o and keys_o go to 0 before the next clk edge; after release, scanning restarts at row 0.

Source files
------------

// File: rtl/keypad_scanner.sv
// Time-multiplexed ROWS x COLS keypad scanner with per-key debounce and a press/release event FIFO.
// Define KEYPAD_SCANNER_RELEASE_EVENT_EN to also queue release events; otherwise only presses are queued.
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  output logic [ROWS-1:0]               row_o,
  input  logic [COLS-1:0]               col_i,
  output logic [ROWS*COLS-1:0]          keys_o,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [$clog2(ROWS*COLS)-1:0]  event_key,
  output logic                          event_press,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int NKEYS = ROWS * COLS;
  localparam int KW    = $clog2(NKEYS);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EMIT} state_t;

  state_t          state, state_next;
  logic [RW-1:0]   row_idx;
  logic [CLW-1:0]  col_idx;
  logic [SW-1:0]   settle_cnt;
  logic [COLS-1:0] sync1, sync2, row_buf;
  logic [CW-1:0]   cnt [NKEYS];

  logic            settle_done, col_last, emit;
  logic [KW-1:0]   key_idx;
  logic            raw, cur, differ, flip;
  logic [CW-1:0]   cur_cnt;
  logic            push, push_press;

  logic [KW-1:0]   mem_key [FIFO_DEPTH];
  logic            mem_press [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, wr_en, drop;

  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign col_last    = (col_idx == CLW'(COLS - 1));
  assign emit        = (state == EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    row_o      = '0;
    case (state)
      IDLE:   if (enable) state_next = DRIVE;
      DRIVE:  if (settle_done) state_next = SAMPLE;
      SAMPLE: state_next = EMIT;
      EMIT:   if (col_last) state_next = enable ? DRIVE : IDLE;
      default: state_next = IDLE;
    endcase
    if (state != IDLE) row_o = ROWS'(1) << row_idx;
  end

  // Row/column sequencing and the column synchronizer; row_buf freezes one row's sample for EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx    <= '0;
      col_idx    <= '0;
      settle_cnt <= '0;
      sync1      <= '0;
      sync2      <= '0;
      row_buf    <= '0;
    end else begin
      sync1 <= col_i;
      sync2 <= sync1;
      if (state == DRIVE && !settle_done) settle_cnt <= settle_cnt + SW'(1);
      else                                settle_cnt <= '0;
      if (state == SAMPLE) row_buf <= sync2;
      if (emit && !col_last) col_idx <= col_idx + CLW'(1);
      else                   col_idx <= '0;
      if (state == IDLE) begin
        row_idx <= '0;
      end else if (emit && col_last) begin
        if (!enable || row_idx == RW'(ROWS - 1)) row_idx <= '0;
        else                                     row_idx <= row_idx + RW'(1);
      end
    end
  end

  assign key_idx = KW'(int'(row_idx) * COLS + int'(col_idx));
  assign raw     = row_buf[col_idx];
  assign cur     = keys_o[key_idx];
  assign cur_cnt = cnt[key_idx];
  assign differ  = (raw != cur);
  assign flip    = emit && differ && (cur_cnt == CW'(DEBOUNCE_SCANS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_o <= '0;
      for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else if (emit) begin
      if (!differ) begin
        cnt[key_idx] <= '0;
      end else if (flip) begin
        keys_o[key_idx] <= raw;
        cnt[key_idx]    <= '0;
      end else begin
        cnt[key_idx] <= cur_cnt + CW'(1);
      end
    end
  end

`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
  assign push       = flip;
  assign push_press = raw;
`else
  assign push       = flip & raw;
  assign push_press = 1'b1;
`endif

  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign event_valid = (count != '0);
  assign pop         = event_valid & event_ready;
  assign wr_en       = push & (~full | pop);
  assign drop        = push & full & ~pop;
  assign event_key   = mem_key[rd_ptr];

`ifdef KEYPAD_SCANNER_RELEASE_EVENT_EN
  assign event_press = mem_press[rd_ptr];
`else
  assign event_press = 1'b1;
`endif

  // Event FIFO: a push into a full FIFO is still accepted when the head is popped in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_key[i]   <= '0;
        mem_press[i] <= 1'b0;
      end
    end else begin
      if (wr_en) begin
        mem_key[wr_ptr]   <= key_idx;
        mem_press[wr_ptr] <= push_press;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule
